// File: rtl/jk_cmd_sequencer.sv
// Buffers hold/clear/set/toggle commands and replays each on registered j/k for rpt+1 cycles, tracking the flip-flop's Q.
// Push-to-j/k latency is one edge; cmd_ready drops when full. Define JKSEQ_FEEDBACK_CHECK_EN to add q_fb/q_err.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int RPT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd,
  input  logic [RPT_W-1:0]       cmd_rpt,
  output logic                   j,
  output logic                   k,
  output logic                   busy,
  output logic                   q_pred,
`ifdef JKSEQ_FEEDBACK_CHECK_EN
  input  logic                   q_fb,
  output logic                   q_err,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  logic [RPT_W+1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_j;
  logic             r_k;
  logic             w_j_nxt;
  logic             w_k_nxt;
  logic [RPT_W-1:0] r_rem;
  logic [RPT_W-1:0] w_rem_nxt;
  logic             r_q;
  logic             w_push;
  logic             w_pop;
  logic             w_have;
  logic [RPT_W+1:0] w_head;

  assign cmd_ready  = (r_count < CW'(DEPTH));
  assign w_push     = cmd_valid & cmd_ready;
  assign w_have     = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign j          = r_j;
  assign k          = r_k;
  assign busy       = (r_state == ISSUE);
  assign q_pred     = r_q;

  // Deciding at rem == 0 lets the next entry load on the same edge, so there is no idle bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_rem_nxt   = r_rem;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_j_nxt = 1'b0;
        w_k_nxt = 1'b0;
        if (w_have) begin
          w_pop       = 1'b1;
          w_state_nxt = ISSUE;
          w_j_nxt     = w_head[RPT_W+1];
          w_k_nxt     = w_head[RPT_W];
          w_rem_nxt   = w_head[RPT_W-1:0];
        end
      end
      ISSUE: begin
        if (r_rem != '0) begin
          w_rem_nxt = r_rem - RPT_W'(1);
        end else if (w_have) begin
          w_pop     = 1'b1;
          w_j_nxt   = w_head[RPT_W+1];
          w_k_nxt   = w_head[RPT_W];
          w_rem_nxt = w_head[RPT_W-1:0];
        end else begin
          w_j_nxt     = 1'b0;
          w_k_nxt     = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd, cmd_rpt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Mirrors the downstream flip-flop: it sees the same j/k we are driving this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else begin
      case ({r_j, r_k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

`ifdef JKSEQ_FEEDBACK_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset)              r_err <= 1'b0;
    else if (q_fb != r_q)   r_err <= 1'b1;
  end

  assign q_err = r_err;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench: driver expands accepted commands into per-cycle j/k expectations; a negedge monitor checks them.
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int RPT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd = 2'b00;
  logic [RPT_W-1:0] cmd_rpt = '0;
  logic             cmd_ready;
  logic             j;
  logic             k;
  logic             busy;
  logic             q_pred;
  logic [2:0]       fifo_count;
`ifdef JKSEQ_FEEDBACK_CHECK_EN
  logic q_fb;
  logic q_err;
  logic ff_q;
  logic inject = 1'b0;
`endif

  jk_cmd_sequencer #(.DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .cmd_rpt    (cmd_rpt),
    .j          (j),
    .k          (k),
    .busy       (busy),
    .q_pred     (q_pred),
`ifdef JKSEQ_FEEDBACK_CHECK_EN
    .q_fb       (q_fb),
    .q_err      (q_err),
`endif
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       first;
    logic [1:0] jk;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] mon_cur;
  int         mon_cnt;
  int         checks = 0;
  int         errors = 0;
  int         n_acc = 0;
  int         n_started = 0;
  int         edge_n = 0;
  logic       q_m = 1'b0;
  logic       mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    case (jk)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  always @(posedge clk) edge_n <= edge_n + 1;

`ifdef JKSEQ_FEEDBACK_CHECK_EN
  always @(posedge clk) begin
    if (reset) ff_q <= 1'b0;
    else       ff_q <= jk_next(ff_q, {j, k});
  end
  assign q_fb = ff_q ^ inject;
`endif

  // Monitor: every cycle consumes one expected j/k when busy and checks predicted Q and occupancy.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = 2'b00;
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_busy", 32'(busy), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.first) n_started++;
          chk("jk", 32'({j, k}), 32'(mon_e.jk));
          mon_cur = mon_e.jk;
        end
      end else begin
        chk("idle_jk", 32'({j, k}), 32'd0);
        if (exp_q.size() != 0 && (!exp_q[0].first || exp_q[0].acc != edge_n))
          chk("stall_busy", 32'(busy), 32'd1);
      end
      mon_cnt = n_acc - n_started;
      chk("q_pred", 32'(q_pred), 32'(q_m));
      chk("fifo_count", 32'(fifo_count), 32'(mon_cnt));
      chk("cmd_ready", 32'(cmd_ready), 32'(mon_cnt < DEPTH));
      q_m = jk_next(q_m, mon_cur);
      if (reset) begin
        exp_q.delete();
        n_started = 0;
        q_m = 1'b0;
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic [RPT_W-1:0] r);
    int g = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = c;
    cmd_rpt = r;
    while (cmd_ready !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("send_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i <= int'(r); i++) exp_q.push_back('{first: (i == 0), jk: c, acc: edge_n});
    n_acc++;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    n_acc = 0;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_jk", 32'({j, k}), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_q", 32'(q_pred), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_count", 32'(fifo_count), 32'd0);

    send(2'b10, 4'd0);
    drain();
    chk("set_q", 32'(q_pred), 32'd1);
    send(2'b01, 4'd0);
    drain();
    send(2'b11, 4'd3);
    drain();
    chk("toggle_final_q", 32'(q_pred), 32'd0);

    send(2'b10, 4'd15);
    for (int i = 0; i < DEPTH; i++) send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 2)));
    @(negedge clk);
    chk("full_count", 32'(fifo_count), 32'(DEPTH));
    chk("full_ready", 32'(cmd_ready), 32'd0);
    send(2'b11, 4'd1);
    drain();

    send(2'b10, 4'd1);
    send(2'b01, 4'd0);
    drain();

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) drain();
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    send(2'b10, 4'd0);
    drain();
    send(2'b11, 4'd7);
    send(2'b10, 4'd2);
    send(2'b01, 4'd1);
    do_reset();
    repeat (6) @(negedge clk);
    send(2'b00, 4'd2);
    send(2'b10, 4'd0);
    drain();

`ifdef JKSEQ_FEEDBACK_CHECK_EN
    chk("q_err_clean", 32'(q_err), 32'd0);
    @(posedge clk);
    #1 inject = 1'b1;
    @(posedge clk);
    #1 inject = 1'b0;
    @(negedge clk);
    chk("q_err_set", 32'(q_err), 32'd1);
    repeat (5) @(negedge clk);
    chk("q_err_sticky", 32'(q_err), 32'd1);
    do_reset();
    chk("q_err_cleared", 32'(q_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
